// File: rtl/stack_pkg.sv
// Shared definitions for the cached data-stack engine: opcode values and
// the refill FSM state encoding.
package stack_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_BINPOP  = 3'd4;
  localparam logic [2:0] OP_DUP     = 3'd5;
  localparam logic [2:0] OP_SWAP    = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LD   = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port spill RAM for entries below NOS: synchronous write and a
// registered read, so dout appears one cycle after the address.
module stack_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or the read register keeps this a plain BRAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cached_stack.sv
// Data-stack engine with TOS/NOS held in registers and deeper entries
// spilled to stack_ram; pops that need a refill stall for two cycles.
module cached_stack
  import stack_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CNT_W-1:0] depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH + 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0] sp_q, sp_d;
  logic             ready_q, ready_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             accept;
  logic             is_full;
  logic             ovf_set;
  logic             unf_set;
  logic             ram_we;
  logic             ram_we_gated;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] push_val;

  assign accept  = op_valid && ready_q;
  assign is_full = (depth_q == FULL_CNT);

  // sp is one bit wider than the RAM address so it can reach DEPTH when full.
  stack_ram #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_gated),
    .addr (sp_q[ADDR_W-1:0]),
    .wdata(nos_q),
    .rdata(ram_rdata)
  );

  assign ram_we_gated = ram_we && !rst;

  always_comb begin
    st_d     = st_q;
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    sp_d     = sp_q;
    ram_we   = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    push_val = (op == OP_DUP) ? tos_q : op_data;

    case (st_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_PUSH, OP_DUP: begin
              if (is_full) begin
                ovf_set = 1'b1;
              end else if (op == OP_DUP && depth_q == '0) begin
                unf_set = 1'b1;
              end else begin
                if (depth_q >= TWO) begin
                  ram_we = 1'b1;
                  sp_d   = sp_q + ONE;
                end
                nos_d   = tos_q;
                tos_d   = push_val;
                depth_d = depth_q + ONE;
              end
            end
            // POP and BINPOP share the NOS refill; only the new TOS differs.
            OP_POP, OP_BINPOP: begin
              if (depth_q < ((op == OP_BINPOP) ? TWO : ONE)) begin
                unf_set = 1'b1;
              end else begin
                tos_d   = (op == OP_POP) ? nos_q : op_data;
                depth_d = depth_q - ONE;
                if (depth_q <= TWO) begin
                  nos_d = '0;
                end else begin
                  sp_d = sp_q - ONE;
                  st_d = ST_RD;
                end
              end
            end
            OP_REPLACE: begin
              if (depth_q == '0) begin
                unf_set = 1'b1;
              end else begin
                tos_d = op_data;
              end
            end
            OP_SWAP: begin
              if (depth_q < TWO) begin
                unf_set = 1'b1;
              end else begin
                tos_d = nos_q;
                nos_d = tos_q;
              end
            end
            OP_CLEAR: begin
              tos_d   = '0;
              nos_d   = '0;
              depth_d = '0;
              sp_d    = '0;
            end
            default: ;
          endcase
        end
      end
      ST_RD: st_d = ST_LD;
      ST_LD: begin
        nos_d = ram_rdata;
        st_d  = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase

    ready_d     = (st_d == ST_IDLE);
    overflow_d  = ovf_set | (overflow_q & ~clear_err);
    underflow_d = unf_set | (underflow_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      tos_q       <= '0;
      nos_q       <= '0;
      depth_q     <= '0;
      sp_q        <= '0;
      ready_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      depth_q     <= depth_d;
      sp_q        <= sp_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign op_ready  = ready_q;
  assign tos       = tos_q;
  assign nos       = nos_q;
  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
